// File: rtl/color_sensor_emulator.sv
// Light-to-frequency colour sensor stand-in: emits a square wave whose
// half-period comes from a per-channel register picked by the synced S2/S3 pins.
module color_sensor_emulator #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  input  logic             s3,
  input  logic             oe_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_chan,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             freq_out,
  output logic [1:0]       active_chan
);

  localparam int HW = CNT_W + 6;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  // Pin bundle {oe_n, s3, s2, s1, s0}; oe_n resets to the disabled level.
  localparam logic [4:0] SYNC_RST = 5'b10000;

  logic [4:0]                    pins;
  logic [SYNC_STAGES-1:0][4:0]   sync_reg;
  logic [4:0]                    synced;

  logic                          s0_sync;
  logic                          s1_sync;
  logic                          s2_sync;
  logic                          s3_sync;
  logic                          oe_n_sync;
  logic [1:0]                    chan_sync;
  logic [1:0]                    scale_sync;

  logic [CNT_W-1:0]              half_reg [4];
  logic                          cfg_ready_reg;

  logic [CNT_W-1:0]              base_raw;
  logic [HW-1:0]                 base_ext;
  logic [HW-1:0]                 half_eff;
  logic [HW-1:0]                 reload_val;
  logic                          run_ok;

  logic [1:0]                    state_reg;
  logic [1:0]                    state_next;
  logic [HW-1:0]                 cnt_reg;
  logic [HW-1:0]                 cnt_next;
  logic                          freq_reg;
  logic                          freq_next;

  assign pins = {oe_n, s3, s2, s1, s0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= {SYNC_STAGES{SYNC_RST}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pins};
    end
  end

  assign synced     = sync_reg[SYNC_STAGES-1];
  assign s0_sync    = synced[0];
  assign s1_sync    = synced[1];
  assign s2_sync    = synced[2];
  assign s3_sync    = synced[3];
  assign oe_n_sync  = synced[4];
  assign chan_sync  = {s2_sync, s3_sync};
  assign scale_sync = {s0_sync, s1_sync};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready_reg <= 1'b0;
    end else begin
      cfg_ready_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        half_reg[i] <= '0;
      end
    end else if (cfg_valid && cfg_ready_reg) begin
      half_reg[cfg_chan] <= cfg_half;
    end
  end

  // A half-period of 1 is stretched to 2 so the output stays a clean square wave.
  assign base_raw = half_reg[chan_sync];

  always_comb begin
    base_ext = HW'(base_raw);
    if (base_raw == CNT_W'(1)) begin
      base_ext = HW'(2);
    end
  end

  always_comb begin
    case (scale_sync)
      2'b01:   half_eff = (base_ext << 5) + (base_ext << 4) + (base_ext << 1);
      2'b10:   half_eff = (base_ext << 2) + base_ext;
      2'b11:   half_eff = base_ext;
      default: half_eff = '0;
    endcase
  end

  assign run_ok     = (scale_sync != 2'b00) && (base_raw != '0);
  assign reload_val = half_eff - HW'(1);

  // Reload is only sampled at a toggle, so mid-phase changes never shorten a phase.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_OFF: begin
        cnt_next = '0;
        if (run_ok) begin
          state_next = ST_LOW;
          cnt_next   = reload_val;
        end
      end
      ST_LOW, ST_HIGH: begin
        if (!run_ok) begin
          state_next = ST_OFF;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = (state_reg == ST_LOW) ? ST_HIGH : ST_LOW;
          cnt_next   = reload_val;
        end else begin
          cnt_next = cnt_reg - HW'(1);
        end
      end
      default: begin
        state_next = ST_OFF;
        cnt_next   = '0;
      end
    endcase
  end

  assign freq_next = (state_reg == ST_HIGH) && !oe_n_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_OFF;
      cnt_reg   <= '0;
      freq_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      freq_reg  <= freq_next;
    end
  end

  assign freq_out    = freq_reg;
  assign cfg_ready   = cfg_ready_reg;
  assign active_chan = chan_sync;

endmodule
